sha256_msg_sched: RTL and testbench

- Streaming message-schedule source for the SHA-256 datapath.
- Accepts one 512-bit message block and emits the 64-entry sequence (W_t, K_t, t) with a valid/ready handshake.
- Its output feeds the w_i/k_i operands of the pipelined compression round core.
- Expansion uses a 16-word sliding window, so only one new word is computed per accepted output.

---
 rtl/sha256_msg_sched.sv | 108 ++++++++++
 tb/tb_sha256_msg_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule source: loads one 512-bit block and streams
// (W_t, K_t, t) for t=0..63 over a valid/ready handshake.
module sha256_msg_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic [511:0] blk_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [31:0]  w_o,
   output logic [31:0]  k_o,
   output logic [5:0]   t_o,
   output logic         last_o,
   output logic         busy_o
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   state_t      state;
   logic [31:0] win [16];
   logic [5:0]  t;
   logic [31:0] w_new;

   // win[0] is always W_t; the new tail word covers W_{t+16}.
   always_comb begin
      w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   end

   assign w_o = win[0];
   assign t_o = t;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         t           <= 6'd0;
         for (int i = 0; i < 16; i++) win[i] <= 32'd0;
         valid_o     <= 1'b0;
         last_o      <= 1'b0;
         busy_o      <= 1'b0;
         blk_ready_o <= 1'b1;
         k_o         <= K_TAB[0];
      end else begin
         case (state)
            IDLE: begin
               if (blk_valid_i) begin
                  for (int i = 0; i < 16; i++) win[i] <= blk_i[511-32*i -: 32];
                  t           <= 6'd0;
                  k_o         <= K_TAB[0];
                  last_o      <= 1'b0;
                  valid_o     <= 1'b1;
                  busy_o      <= 1'b1;
                  blk_ready_o <= 1'b0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (ready_i) begin
                  if (t == 6'd63) begin
                     t           <= 6'd0;
                     k_o         <= K_TAB[0];
                     last_o      <= 1'b0;
                     valid_o     <= 1'b0;
                     busy_o      <= 1'b0;
                     blk_ready_o <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                     win[15] <= w_new;
                     t       <= t + 6'd1;
                     k_o     <= K_TAB[t + 6'd1];
                     last_o  <= (t == 6'd62);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: random blocks and ready_i
// compared against a FIPS 180-4 style schedule model.
module tb_sha256_msg_sched;

   logic         clk;
   logic         rst_n;
   logic         blk_valid_i;
   logic         blk_ready_o;
   logic [511:0] blk_i;
   logic         valid_o;
   logic         ready_i;
   logic [31:0]  w_o;
   logic [31:0]  k_o;
   logic [5:0]   t_o;
   logic         last_o;
   logic         busy_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] expW [64];
   logic [31:0] gotW [64];
   logic [31:0] gotK [64];
   logic        gotLast [64];

   localparam logic [31:0] K_REF [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   sha256_msg_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .blk_valid_i(blk_valid_i),
      .blk_ready_o(blk_ready_o),
      .blk_i      (blk_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .w_o        (w_o),
      .k_o        (k_o),
      .t_o        (t_o),
      .last_o     (last_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Full 64-word schedule straight from the textbook recurrence.
   task automatic buildModel(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) expW[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         logic [31:0] s0, s1;
         s0 = rotr(expW[i-15], 7) ^ rotr(expW[i-15], 18) ^ (expW[i-15] >> 3);
         s1 = rotr(expW[i-2], 17) ^ rotr(expW[i-2], 19) ^ (expW[i-2] >> 10);
         expW[i] = s1 + expW[i-7] + s0 + expW[i-16];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] randBlock();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
      return b;
   endfunction

   // Offers a block from IDLE, then consumes and checks all 64 words.
   // Called and returns just after a falling edge.
   task automatic applyStimulus(input logic [511:0] blk, input bit randReady,
                                input bit holdValid, input logic [511:0] nextBlk,
                                input bit glitch);
      int  idx, cyc, waitCnt;
      bit  glitchDone, prevStall;
      logic [31:0] prevW;
      buildModel(blk);
      blk_i       = blk;
      blk_valid_i = 1'b1;
      ready_i     = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      checkOutput("accept latency", {31'd0, valid_o}, 32'd1);
      waitCnt = 0;
      while (!valid_o && waitCnt < 100) begin
         @(negedge clk);
         waitCnt++;
      end
      blk_valid_i = holdValid;
      if (holdValid) blk_i = nextBlk;
      idx = 0;
      cyc = 0;
      glitchDone = 1'b0;
      prevStall = 1'b0;
      prevW = 32'd0;
      while (idx < 64 && cyc < 1000) begin
         checkOutput($sformatf("status t=%0d", idx), {29'd0, valid_o, busy_o, blk_ready_o}, 32'd6);
         checkOutput($sformatf("w t=%0d", idx), w_o, expW[idx]);
         checkOutput($sformatf("k t=%0d", idx), k_o, K_REF[idx]);
         checkOutput($sformatf("t_o t=%0d", idx), {26'd0, t_o}, idx);
         checkOutput($sformatf("last t=%0d", idx), {31'd0, last_o}, {31'd0, idx == 63});
         if (prevStall) checkOutput($sformatf("stall hold t=%0d", idx), w_o, prevW);
         gotW[idx]    = w_o;
         gotK[idx]    = k_o;
         gotLast[idx] = last_o;
         prevW        = w_o;
         if (glitch && !glitchDone && idx == 20) begin
            blk_valid_i = 1'b1;
            blk_i       = randBlock();
            glitchDone  = 1'b1;
         end else if (glitchDone && !holdValid) begin
            blk_valid_i = 1'b0;
         end
         ready_i   = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         prevStall = !ready_i;
         if (ready_i) idx++;
         cyc++;
         @(negedge clk);
      end
      checkOutput("fire count", idx, 64);
      if (!randReady) checkOutput("burst cycles", cyc, 64);
      checkOutput("idle status", {29'd0, valid_o, busy_o, blk_ready_o}, 32'd1);
      checkOutput("idle t_o", {26'd0, t_o}, 32'd0);
      checkOutput("idle last", {31'd0, last_o}, 32'd0);
   endtask

   initial begin
      logic [511:0] abc, b1, b2;
      int waitCnt;
      rst_n       = 1'b0;
      blk_valid_i = 1'b0;
      blk_i       = '0;
      ready_i     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset status", {29'd0, valid_o, busy_o, blk_ready_o}, 32'd1);
      checkOutput("reset last", {31'd0, last_o}, 32'd0);
      checkOutput("reset w", w_o, 32'd0);
      checkOutput("reset k", k_o, 32'h428a2f98);
      checkOutput("reset t", {26'd0, t_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] abc block");
      abc = '0;
      abc[511:480] = 32'h61626380;
      abc[31:0]    = 32'h00000018;
      applyStimulus(abc, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("abc W0", gotW[0], 32'h61626380);
      checkOutput("abc W15", gotW[15], 32'h00000018);
      checkOutput("abc W16", gotW[16], 32'h61626380);
      checkOutput("abc W17", gotW[17], 32'h000f0000);
      checkOutput("abc K0", gotK[0], 32'h428a2f98);
      checkOutput("abc K63", gotK[63], 32'hc67178f2);
      checkOutput("abc last63", {31'd0, gotLast[63]}, 32'd1);

      $display("[TB] random ready");
      applyStimulus(randBlock(), 1'b1, 1'b0, '0, 1'b0);

      $display("[TB] back-to-back");
      b1 = randBlock();
      b2 = randBlock();
      applyStimulus(b1, 1'b1, 1'b1, b2, 1'b0);
      applyStimulus(b2, 1'b0, 1'b0, '0, 1'b0);

      $display("[TB] reset mid-block");
      blk_i       = randBlock();
      blk_valid_i = 1'b1;
      ready_i     = 1'b1;
      @(negedge clk);
      blk_valid_i = 1'b0;
      waitCnt = 0;
      while (!(valid_o && t_o == 6'd30) && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("reach t=30", {26'd0, t_o}, 32'd30);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("midreset status", {29'd0, valid_o, busy_o, blk_ready_o}, 32'd1);
      checkOutput("midreset t", {26'd0, t_o}, 32'd0);
      @(negedge clk);
      checkOutput("midreset quiet", {31'd0, valid_o}, 32'd0);
      applyStimulus(randBlock(), 1'b1, 1'b0, '0, 1'b0);

      $display("[TB] all-ones block");
      applyStimulus({512{1'b1}}, 1'b0, 1'b0, '0, 1'b0);

      $display("[TB] blk_valid_i during run");
      applyStimulus(randBlock(), 1'b1, 1'b0, '0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
